exec_alu_unit: RTL

//  Execute-stage ALU feeding conditionCheck: computes result plus NZCV ALUFlags for ALU ops.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/exec_alu_unit_if.sv | 31 +++
 rtl/seq_multiplier.sv | 60 ++++++
 rtl/exec_alu_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM encoding and
// the NZCV bit positions that conditionCheck expects.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_EOR  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_MOV  = 3'b110;
    localparam logic [2:0] ALU_RSVD = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_alu_unit_if.sv
// Operand/result bus between the issue logic and the execute-stage ALU.
//
// Handshake: an operation transfers on a rising clock edge where
// in_valid & in_ready & ~flush are all high; the issuer keeps in_valid,
// alu_ctrl, src_a and src_b stable until that edge. There is no
// backpressure on the result side: out_valid is a one-cycle pulse marking
// the cycle in which result/alu_flags were updated, and those outputs hold
// their value until the next pulse.
interface exec_alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_flags;
    logic             out_valid;

    modport master (
        output flush, in_valid, alu_ctrl, src_a, src_b,
        input  in_ready, result, alu_flags, out_valid
    );

    modport slave (
        input  flush, in_valid, alu_ctrl, src_a, src_b,
        output in_ready, result, alu_flags, out_valid
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier. The first partial product is folded in on
// the start edge, so WIDTH steps finish WIDTH-1 cycles after start; done is
// high in the cycle whose edge would take the final step, with product
// already showing the complete low WIDTH bits of a*b.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] addend;

    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign product = acc_q + addend;
    assign done    = busy_q && (cnt_q == LAST);

    // Accumulate one partial product per cycle; abort drops the operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            acc_q    <= b[0] ? a : '0;
            mcand_q  <= a << 1;
            mplier_q <= b >> 1;
            cnt_q    <= CW'(1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                acc_q    <= product;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/logic/MOV with a registered
// result, plus an iterative MUL. Produces NZCV flags for conditionCheck.
// result/alu_flags only change together with the out_valid pulse.
module exec_alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    exec_alu_unit_if.slave    bus,
    output alu_state_e        dbg_state
);
    alu_state_e       state_q, state_d;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_c, sc_v;
    logic             commit_en;
    logic [WIDTH-1:0] commit_res;
    logic             commit_c, commit_v;
    logic [3:0]       flags_d;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;
    logic             ov_q;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
    assign is_mul        = (bus.alu_ctrl == ALU_MUL);
    assign mul_start     = accept & is_mul;
    assign dbg_state     = state_q;
    assign bus.result    = res_q;
    assign bus.alu_flags = flags_q;
    assign bus.out_valid = ov_q;

    // Subtraction uses A + ~B + 1 so the carry-out reads as "no borrow".
    assign add_sum  = {1'b0, bus.src_a} + {1'b0, bus.src_b};
    assign sub_diff = {1'b0, bus.src_a} + {1'b0, ~bus.src_b} + {{WIDTH{1'b0}}, 1'b1};

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (bus.flush),
        .a       (bus.src_a),
        .b       (bus.src_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: RUN while a MUL iterates; flush or completion returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_RUN;
            S_RUN:   if (bus.flush || mul_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle datapath with carry/overflow for ADD and SUB.
    always_comb begin
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (bus.alu_ctrl)
            ALU_ADD: begin
                sc_result = add_sum[WIDTH-1:0];
                sc_c      = add_sum[WIDTH];
                sc_v      = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result = sub_diff[WIDTH-1:0];
                sc_c      = sub_diff[WIDTH];
                sc_v      = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            ALU_AND: sc_result = bus.src_a & bus.src_b;
            ALU_ORR: sc_result = bus.src_a | bus.src_b;
            ALU_EOR: sc_result = bus.src_a ^ bus.src_b;
            ALU_MOV: sc_result = bus.src_b;
            default: sc_result = '0;
        endcase
    end

    // Pick what completes this edge; flush suppresses a finishing MUL.
    always_comb begin
        commit_en  = 1'b0;
        commit_res = sc_result;
        commit_c   = sc_c;
        commit_v   = sc_v;
        if (accept && !is_mul) begin
            commit_en = 1'b1;
        end else if ((state_q == S_RUN) && mul_done && !bus.flush) begin
            commit_en  = 1'b1;
            commit_res = mul_product;
            commit_c   = 1'b0;
            commit_v   = 1'b0;
        end
        flags_d         = '0;
        flags_d[FLAG_N] = commit_res[WIDTH-1];
        flags_d[FLAG_Z] = (commit_res == '0);
        flags_d[FLAG_C] = commit_c;
        flags_d[FLAG_V] = commit_v;
    end

    // Output registers: updated only on completion, out_valid pulses once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q   <= '0;
            flags_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            ov_q <= commit_en;
            if (commit_en) begin
                res_q   <= commit_res;
                flags_q <= flags_d;
            end
        end
    end
endmodule
